// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch and the MEM stage.
// A granted request is latched and held on the RAM port for MEM_LAT cycles. Read data
// is then captured and a one-cycle done pulse is raised. MEM has priority over fetch,
// and a starvation counter forces a fetch grant after STARVE_MAX back-to-back MEM grants
// that were made while fetch was waiting.
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,  // RAM access latency in cycles (>= 1)
   parameter int STARVE_MAX = 3,  // consecutive MEM grants tolerated while fetch waits
   parameter int CW         = 2   // latency counter width, must hold MEM_LAT-1
) (
   input  logic        clk,
   input  logic        Reset,
   // instruction fetch port
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic [31:0] fetch_rdata,
   output logic        fetch_done,
   // data (MEM stage) port
   input  logic        mem_req,
   input  logic        mem_rw,
   input  logic        mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   // RAM port
   output logic        ram_en,
   output logic        ram_rw,
   output logic        ram_size,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   // hazard unit
   output logic        if_stall,
   output logic        mem_stall
);

   localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LAT - 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FETCH_BUSY = 2'd1,
      DATA_BUSY  = 2'd2
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [SW-1:0] starve_q, starve_d;

   // Latched access presented on the RAM port; all zero while idle.
   logic          en_q, rw_q, size_q;
   logic [31:0]   addr_q, wdata_q;

   logic [31:0]   fetch_rdata_q, mem_rdata_q;
   logic          fetch_done_q, mem_done_q;

   logic          grant_pt, complete;
   logic          fetch_elig, mem_elig, force_fetch;
   logic          grant_mem, grant_fetch;

   // Grant decision and next starvation count for the current cycle.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      grant_pt    = 1'b0;
      complete    = 1'b0;
      fetch_elig  = 1'b0;
      mem_elig    = 1'b0;
      force_fetch = 1'b0;
      grant_mem   = 1'b0;
      grant_fetch = 1'b0;
      starve_d    = starve_q;

      // The last busy cycle (cnt==0) is also a grant point, so accesses chain back to back.
      complete = (state_q != IDLE) && (cnt_q == '0);
      grant_pt = (state_q == IDLE) || complete;

      // A request is ignored while its own done pulse is showing.
      fetch_elig  = fetch_req && !fetch_done_q;
      mem_elig    = mem_req && !mem_done_q;
      force_fetch = (starve_q == STARVE_TOP) && fetch_elig;

      grant_mem   = grant_pt && mem_elig && !force_fetch;
      grant_fetch = grant_pt && fetch_elig && !grant_mem;

      if (grant_mem) begin
         if (!fetch_req)
            starve_d = '0;
         else if (starve_q != STARVE_TOP)
            starve_d = starve_q + SW'(1);
      end else if (grant_fetch) begin
         starve_d = '0;
      end
   end

   // Arbiter FSM: grants, latency count, RAM port registers, read capture and done pulses.
   always_ff @(posedge clk or posedge Reset) begin
      // NOTE: the read-data registers are reset too, because every output must read 0 in reset.
      if (Reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         starve_q      <= '0;
         en_q          <= 1'b0;
         rw_q          <= 1'b0;
         size_q        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         fetch_rdata_q <= '0;
         mem_rdata_q   <= '0;
         fetch_done_q  <= 1'b0;
         mem_done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so a later grant load overrides the defaults below.
         fetch_done_q <= 1'b0;
         mem_done_q   <= 1'b0;
         starve_q     <= starve_d;

         if (state_q != IDLE && cnt_q != '0)
            cnt_q <= cnt_q - CW'(1);

         if (complete) begin
            if (state_q == FETCH_BUSY) begin
               fetch_rdata_q <= ram_rdata;
               fetch_done_q  <= 1'b1;
            end else begin
               if (!rw_q)
                  mem_rdata_q <= ram_rdata;
               mem_done_q <= 1'b1;
            end
         end

         if (grant_mem) begin
            state_q <= DATA_BUSY;
            cnt_q   <= CNT_LOAD;
            en_q    <= 1'b1;
            rw_q    <= mem_rw;
            size_q  <= mem_size;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
         end else if (grant_fetch) begin
            state_q <= FETCH_BUSY;
            cnt_q   <= CNT_LOAD;
            en_q    <= 1'b1;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= fetch_addr;
            wdata_q <= '0;
         end else if (grant_pt) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
         end
      end
   end

   assign ram_en      = en_q;
   assign ram_rw      = rw_q;
   assign ram_size    = size_q;
   assign ram_addr    = addr_q;
   assign ram_wdata   = wdata_q;

   assign fetch_rdata = fetch_rdata_q;
   assign fetch_done  = fetch_done_q;
   assign mem_rdata   = mem_rdata_q;
   assign mem_done    = mem_done_q;

   // Stalls are gated by reset so that every output reads 0 while reset is held.
   assign if_stall    = fetch_req && !fetch_done_q && !Reset;
   assign mem_stall   = mem_req && !mem_done_q && !Reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios and then randomized fetch/data masters.
// Every cycle is checked against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 3;
   localparam int CW         = 2;

   logic        clk = 1'b0;
   logic        Reset;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic [31:0] fetch_rdata;
   logic        fetch_done;
   logic        mem_req, mem_rw, mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_done;
   logic        ram_en, ram_rw, ram_size;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic        if_stall, mem_stall;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX), .CW(CW)) dut (
      .clk(clk), .Reset(Reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_rdata(fetch_rdata), .fetch_done(fetch_done),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .ram_en(ram_en), .ram_rw(ram_rw), .ram_size(ram_size),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .if_stall(if_stall), .mem_stall(mem_stall)
   );

   // Reference model: the owner of the port (0 none, 1 fetch, 2 data), the busy cycles
   // still left for that owner, the access on the port, and the values returned to each master.
   int          m_owner, m_left, m_starve;
   logic [31:0] m_addr, m_wdata, m_frdata, m_mrdata;
   logic        m_rw, m_size, m_fdone, m_mdone;
   int          grant_log[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Master behaviour knobs: percent chance of a new request, percent chance of dropping.
   int p_f, p_m, p_drop;
   bit rand_rd;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner  = 0;
      m_left   = 0;
      m_starve = 0;
      m_addr   = '0;
      m_wdata  = '0;
      m_rw     = 1'b0;
      m_size   = 1'b0;
      m_frdata = '0;
      m_mrdata = '0;
      m_fdone  = 1'b0;
      m_mdone  = 1'b0;
   endtask

   // Advance the model by one rising edge, using the inputs as they were before the edge.
   task automatic model_edge();
      bit nf, nm, at_grant, fe, me;
      nf       = 1'b0;
      nm       = 1'b0;
      at_grant = (m_owner == 0) || (m_left == 1);
      fe       = fetch_req && !m_fdone;
      me       = mem_req && !m_mdone;

      if (m_owner != 0) begin
         if (m_left == 1) begin
            if (m_owner == 1) begin
               m_frdata = ram_rdata;
               nf = 1'b1;
            end else begin
               if (!m_rw) m_mrdata = ram_rdata;
               nm = 1'b1;
            end
         end else begin
            m_left--;
         end
      end

      if (at_grant) begin
         if (me && !(m_starve == STARVE_MAX && fe)) begin
            m_owner = 2;
            m_left  = MEM_LAT;
            m_addr  = mem_addr;
            m_rw    = mem_rw;
            m_size  = mem_size;
            m_wdata = mem_wdata;
            m_starve = !fetch_req ? 0 : (m_starve < STARVE_MAX ? m_starve + 1 : m_starve);
            grant_log.push_back(2);
         end else if (fe) begin
            m_owner  = 1;
            m_left   = MEM_LAT;
            m_addr   = fetch_addr;
            m_rw     = 1'b0;
            m_size   = 1'b0;
            m_wdata  = '0;
            m_starve = 0;
            grant_log.push_back(1);
         end else begin
            m_owner = 0;
            m_left  = 0;
            m_addr  = '0;
            m_rw    = 1'b0;
            m_size  = 1'b0;
            m_wdata = '0;
         end
      end
      m_fdone = nf;
      m_mdone = nm;
   endtask

   task automatic check_regs();
      check1 ("ram_en",      ram_en,      m_owner != 0);
      check1 ("ram_rw",      ram_rw,      m_rw);
      check1 ("ram_size",    ram_size,    m_size);
      check32("ram_addr",    ram_addr,    m_addr);
      check32("ram_wdata",   ram_wdata,   m_wdata);
      check32("fetch_rdata", fetch_rdata, m_frdata);
      check1 ("fetch_done",  fetch_done,  m_fdone);
      check32("mem_rdata",   mem_rdata,   m_mrdata);
      check1 ("mem_done",    mem_done,    m_mdone);
   endtask

   task automatic check_stalls();
      check1("if_stall",  if_stall,  fetch_req && !m_fdone && !Reset);
      check1("mem_stall", mem_stall, mem_req && !m_mdone && !Reset);
   endtask

   task automatic new_mem();
      mem_req   = 1'b1;
      mem_rw    = 1'($urandom_range(1));
      mem_size  = 1'($urandom_range(1));
      mem_addr  = $urandom;
      mem_wdata = $urandom;
   endtask

   // Masters hold a request until they see its done pulse, then issue another or go quiet.
   task automatic drive_masters();
      if (fetch_req && m_fdone) begin
         if (int'($urandom_range(99)) < p_f) fetch_addr = fetch_addr + 32'd4;
         else fetch_req = 1'b0;
      end else if (!fetch_req) begin
         if (int'($urandom_range(99)) < p_f) begin
            fetch_req  = 1'b1;
            fetch_addr = $urandom & 32'hFFFF_FFFC;
         end
      end else if (int'($urandom_range(99)) < p_drop) begin
         fetch_req = 1'b0;
      end

      if (mem_req && m_mdone) begin
         if (int'($urandom_range(99)) < p_m) new_mem();
         else mem_req = 1'b0;
      end else if (!mem_req) begin
         if (int'($urandom_range(99)) < p_m) new_mem();
      end else if (int'($urandom_range(99)) < p_drop) begin
         mem_req = 1'b0;
      end

      if (rand_rd) ram_rdata = $urandom;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
      drive_masters();
      #1;
      check_stalls();
   endtask

   initial begin
      Reset      = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = '0;
      mem_req    = 1'b1;
      mem_rw     = 1'b0;
      mem_size   = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      ram_rdata  = '0;
      p_f = 0; p_m = 0; p_drop = 0; rand_rd = 1'b0;
      model_reset();

      // Reset state, with both requests high: everything reads 0.
      #3;
      check_regs();
      check_stalls();
      fetch_req = 1'b0;
      mem_req   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) Reset = 1'b0;

      // Single fetch from 0x8; the word shows up after MEM_LAT busy cycles.
      fetch_req  = 1'b1;
      fetch_addr = 32'h8;
      ram_rdata  = 32'hE082_5005;
      repeat (6) cycle();
      check32("t2_fetch_word", fetch_rdata, 32'hE082_5005);

      // Fetch and byte write raised together: MEM first with rw=1, size=1.
      fetch_req  = 1'b1;
      fetch_addr = 32'h10;
      mem_req    = 1'b1;
      mem_rw     = 1'b1;
      mem_size   = 1'b1;
      mem_addr   = 32'h4;
      mem_wdata  = 32'hA5;
      ram_rdata  = 32'h1234_5678;
      cycle();
      check32("t3_ram_addr", ram_addr, 32'h4);
      check1 ("t3_ram_rw",   ram_rw,   1'b1);
      check1 ("t3_ram_size", ram_size, 1'b1);
      repeat (10) cycle();

      // Word load from 12; the earlier fetch word must stay put.
      mem_req   = 1'b1;
      mem_rw    = 1'b0;
      mem_size  = 1'b0;
      mem_addr  = 32'hC;
      ram_rdata = 32'h0000_002A;
      repeat (8) cycle();
      check32("t6_load",      mem_rdata,   32'h0000_002A);
      check32("t6_fetch_kept", fetch_rdata, 32'h1234_5678);

      // Reset in the middle of a data access: outputs drop at once, no done pulse follows.
      mem_req  = 1'b1;
      mem_addr = 32'h20;
      cycle();
      check1("t1_busy_before", ram_en, 1'b1);
      Reset = 1'b1;
      #1;
      model_reset();
      check_regs();
      check_stalls();
      mem_req = 1'b0;
      @(posedge clk);
      #1;
      check_regs();
      @(negedge clk) Reset = 1'b0;
      #1;
      check_stalls();

      // Both masters saturated: grants run M,M,M,F over and over.
      grant_log.delete();
      p_f = 100; p_m = 100; p_drop = 0; rand_rd = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      new_mem();
      repeat (40) cycle();
      check1("t4_enough_grants", grant_log.size() >= 8, 1'b1);
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         check32("t4_grant_order", 32'(grant_log[i]), (i % 4 == 3) ? 32'd1 : 32'd2);

      // Randomized traffic, including requests dropped mid-access.
      p_f = 60; p_m = 50; p_drop = 3;
      repeat (1500) cycle();

      // Quiet tail: everything drains back to idle.
      p_f = 0; p_m = 0; p_drop = 100;
      repeat (10) cycle();
      check1("drain_idle", ram_en, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
